// File: rtl/risc_net_pkg.sv
// Shared widths, opcode constants and the decoded-entry layout for the RISC-Net pipeline.
package risc_net_pkg;

    localparam int OPC_W   = 8;
    localparam int FIELD_W = 12;
    localparam int OP_W    = 16;
    localparam int INSTR_W = OPC_W + 2 * FIELD_W;
    localparam int NUM_OPS = 16;
    localparam int CNT_W   = 8;

    // The opcode MSB marks an immediate form, which sign-extends the second operand.
    localparam int IMM_BIT = OPC_W - 1;

    localparam logic [OPC_W-1:0] OPC_NOP = 8'h00;
    localparam logic [OPC_W-1:0] OPC_ADD = 8'h01;
    localparam logic [OPC_W-1:0] OPC_SUB = 8'h02;
    localparam logic [OPC_W-1:0] OPC_AND = 8'h03;
    localparam logic [OPC_W-1:0] OPC_OR  = 8'h04;
    localparam logic [OPC_W-1:0] OPC_XOR = 8'h05;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OP_W-1:0]  op1;
        logic [OP_W-1:0]  op2;
        logic             illegal;
    } decoded_t;

endpackage

// File: rtl/instr_decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage, plus flush and the illegal count.
interface instr_decode_pipe_if #(
    parameter int INSTR_W = risc_net_pkg::INSTR_W,
    parameter int OPC_W   = risc_net_pkg::OPC_W,
    parameter int OP_W    = risc_net_pkg::OP_W,
    parameter int CNT_W   = risc_net_pkg::CNT_W
) ();

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   opcode;
    logic [OP_W-1:0]    op1;
    logic [OP_W-1:0]    op2;
    logic               illegal;
    logic [CNT_W-1:0]   illegal_cnt;

    modport master (
        output flush, in_valid, instruction, out_ready,
        input  in_ready, out_valid, opcode, op1, op2, illegal, illegal_cnt
    );

    modport slave (
        input  flush, in_valid, instruction, out_ready,
        output in_ready, out_valid, opcode, op1, op2, illegal, illegal_cnt
    );

endinterface

// File: rtl/instr_decode_pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with flush; R0 drives the output, R1 absorbs one stalled beat.
module decode_skid_buf #(
    parameter int WIDTH = $bits(risc_net_pkg::decoded_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] r0_q, r0_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic             inReady_q, inReady_d;
    logic             accept;
    logic             deliver;

    assign accept      = in_valid_i && inReady_q;
    assign deliver     = (state_q != OCC_EMPTY) && out_ready_i;
    assign in_ready_o  = inReady_q;
    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = r0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            r0_q      <= '0;
            r1_q      <= '0;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            inReady_q <= inReady_d;
        end
    end

    // Accept is impossible in OCC_TWO because ready was already low there.
    always_comb begin
        state_d = state_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        r0_d    = in_data_i;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && deliver) begin
                        r0_d = in_data_i;
                    end else if (deliver) begin
                        state_d = OCC_EMPTY;
                    end else if (accept) begin
                        r1_d    = in_data_i;
                        state_d = OCC_TWO;
                    end
                end
                OCC_TWO: begin
                    if (deliver) begin
                        r0_d    = r1_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        inReady_d = (state_d != OCC_TWO);
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// RISC-Net decode stage: splits an instruction into opcode and extended operands, buffers it
// behind a two-entry skid buffer and keeps a saturating count of delivered illegal entries.
module instr_decode_pipe #(
    parameter int          INSTR_W = risc_net_pkg::INSTR_W,
    parameter int          OPC_W   = risc_net_pkg::OPC_W,
    parameter int          FIELD_W = risc_net_pkg::FIELD_W,
    parameter int          OP_W    = risc_net_pkg::OP_W,
    parameter int unsigned NUM_OPS = risc_net_pkg::NUM_OPS,
    parameter int          CNT_W   = risc_net_pkg::CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    instr_decode_pipe_if.slave bus
);

    import risc_net_pkg::*;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OP_W-1:0]  op1;
        logic [OP_W-1:0]  op2;
        logic             illegal;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [OPC_W-1:0]   opcField;
    logic [FIELD_W-1:0] field1;
    logic [FIELD_W-1:0] field2;
    logic               legal;
    entry_t             decoded;
    entry_t             held;
    logic [ENTRY_W-1:0] heldBits;
    logic               inReady;
    logic               outValid;
    logic [CNT_W-1:0]   illegalCnt_q, illegalCnt_d;

    assign opcField = bus.instruction[OPC_W-1:0];
    assign field1   = bus.instruction[OPC_W+FIELD_W-1:OPC_W];
    assign field2   = bus.instruction[INSTR_W-1:OPC_W+FIELD_W];
    assign legal    = (32'(opcField[OPC_W-2:0]) < NUM_OPS);

    // Illegal opcodes are squashed to a NOP with zero operands but still flow downstream.
    always_comb begin
        decoded         = '0;
        decoded.opcode  = OPC_W'(OPC_NOP);
        decoded.illegal = 1'b1;
        if (legal) begin
            decoded.opcode  = opcField;
            decoded.op1     = OP_W'(field1);
            decoded.op2     = opcField[OPC_W-1] ? OP_W'($signed(field2)) : OP_W'(field2);
            decoded.illegal = 1'b0;
        end
    end

    decode_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (bus.flush),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (inReady),
        .in_data_i   (decoded),
        .out_valid_o (outValid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (heldBits)
    );

    assign held = heldBits;

    // A delivery coinciding with flush still leaves the stage but is deliberately not counted.
    always_comb begin
        illegalCnt_d = illegalCnt_q;
        if (outValid && bus.out_ready && !bus.flush && held.illegal && (illegalCnt_q != '1)) begin
            illegalCnt_d = illegalCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegalCnt_q <= '0;
        end else begin
            illegalCnt_q <= illegalCnt_d;
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.opcode      = held.opcode;
    assign bus.op1         = held.op1;
    assign bus.op2         = held.op2;
    assign bus.illegal     = held.illegal;
    assign bus.illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe: stimulus pushes reference decodes at accept,
// a negedge monitor pops and compares on every presented output.
module tb_instr_decode_pipe;

    import risc_net_pkg::*;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_decode_pipe_if ifc ();

    instr_decode_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    decoded_t expQ[$];
    int       testsRun   = 0;
    int       testsFailed = 0;
    int       modelCnt   = 0;
    bit       randReady  = 1'b0;

    // Reference decode from the field rules using plain integer arithmetic.
    function automatic decoded_t refDecode(input logic [31:0] instr);
        decoded_t    r;
        int unsigned word, opc, base, f1, f2;
        word = instr;
        opc  = word % 256;
        base = opc % 128;
        f1   = (word / 256) % 4096;
        f2   = word / 1048576;
        r    = '0;
        if (base >= NUM_OPS) begin
            r.illegal = 1'b1;
            return r;
        end
        if (opc >= 128 && f2 >= 2048) f2 = f2 + 65536 - 4096;
        r.opcode = 8'(opc);
        r.op1    = 16'(f1);
        r.op2    = 16'(f2);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the instruction until accepted; the expected decode is queued at the accepting edge.
    task automatic applyStimulus(input logic [31:0] instr);
        bit done;
        bit acc;
        done = 1'b0;
        ifc.in_valid    = 1'b1;
        ifc.instruction = instr;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = ifc.in_ready && !ifc.flush;
            @(posedge clk);
            if (acc) begin
                expQ.push_back(refDecode(instr));
                done = 1'b1;
            end
            #1;
        end
        ifc.in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic applyFlush(input bit withInput, input logic [31:0] instr);
        ifc.flush       = 1'b1;
        ifc.in_valid    = withInput;
        ifc.instruction = instr;
        @(posedge clk);
        #1;
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
        checkOutput("drain", 64'(expQ.size()), 64'd0);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [31:0] instr;
        instr = $urandom;
        if ($urandom_range(0, 3) != 0) instr[6:0] = 7'($urandom_range(0, 15));
        return instr;
    endfunction

    always @(posedge clk) begin
        #2;
        if (randReady) ifc.out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("out_valid", 64'(ifc.out_valid), 64'(expQ.size() != 0));
            checkOutput("in_ready", 64'(ifc.in_ready), 64'(expQ.size() < 2));
            checkOutput("illegal_cnt", 64'(ifc.illegal_cnt), 64'(modelCnt));
            if (ifc.out_valid && expQ.size() != 0) begin
                checkOutput("entry", 64'({ifc.opcode, ifc.op1, ifc.op2, ifc.illegal}), 64'(expQ[0]));
                if (ifc.out_ready) begin
                    if (!ifc.flush && expQ[0].illegal && modelCnt < CNT_MAX) modelCnt++;
                    void'(expQ.pop_front());
                end
            end
            if (ifc.flush) expQ.delete();
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] instr;
        ifc.flush       = 1'b0;
        ifc.in_valid    = 1'b0;
        ifc.instruction = '0;
        ifc.out_ready   = 1'b0;
        rst_n           = 1'b0;

        #12;
        checkOutput("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        checkOutput("rst_opcode", 64'(ifc.opcode), 64'd0);
        checkOutput("rst_ops", 64'({ifc.op1, ifc.op2}), 64'd0);
        checkOutput("rst_illegal", 64'(ifc.illegal), 64'd0);
        checkOutput("rst_cnt", 64'(ifc.illegal_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        ifc.out_ready = 1'b1;
        applyStimulus(32'h0FF0_0A05);
        @(negedge clk);
        checkOutput("plain_valid", 64'(ifc.out_valid), 64'd1);
        checkOutput("plain_opcode", 64'(ifc.opcode), 64'h05);
        checkOutput("plain_op1", 64'(ifc.op1), 64'h000A);
        checkOutput("plain_op2", 64'(ifc.op2), 64'h00FF);
        checkOutput("plain_illegal", 64'(ifc.illegal), 64'd0);
        idle(1);

        applyStimulus(32'hF000_0185);
        @(negedge clk);
        checkOutput("imm_opcode", 64'(ifc.opcode), 64'h85);
        checkOutput("imm_op1", 64'(ifc.op1), 64'h0001);
        checkOutput("imm_op2", 64'(ifc.op2), 64'hFF00);
        idle(1);

        applyStimulus(32'h1234_561F);
        @(negedge clk);
        checkOutput("ill_opcode", 64'(ifc.opcode), 64'd0);
        checkOutput("ill_ops", 64'({ifc.op1, ifc.op2}), 64'd0);
        checkOutput("ill_flag", 64'(ifc.illegal), 64'd1);
        idle(1);
        @(negedge clk);
        checkOutput("ill_cnt_one", 64'(ifc.illegal_cnt), 64'd1);
        idle(1);

        // Backpressure: A and B fill the buffer, C must wait.
        ifc.out_ready = 1'b0;
        applyStimulus(32'h0003_2001);
        applyStimulus(32'h8FF1_2382);
        fork
            applyStimulus(32'h0450_0303);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", 64'(ifc.in_ready), 64'd0);
                    checkOutput("bp_hold_opcode", 64'(ifc.opcode), 64'h01);
                end
                @(posedge clk);
                #1;
                ifc.out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two entries held and a new instruction offered.
        ifc.out_ready = 1'b0;
        applyStimulus(32'h0011_1102);
        applyStimulus(32'h0022_2203);
        applyFlush(1'b1, 32'h0777_7704);
        @(negedge clk);
        checkOutput("flush2_out_valid", 64'(ifc.out_valid), 64'd0);
        checkOutput("flush2_in_ready", 64'(ifc.in_ready), 64'd1);
        idle(1);
        ifc.out_ready = 1'b1;
        idle(3);
        checkOutput("flush2_nothing_left", 64'(expQ.size()), 64'd0);

        // Flush with one entry held while an accept would otherwise happen.
        ifc.out_ready = 1'b0;
        applyStimulus(32'h0033_3305);
        applyFlush(1'b1, 32'h0888_8806);
        @(negedge clk);
        checkOutput("flush1_out_valid", 64'(ifc.out_valid), 64'd0);
        idle(1);
        ifc.out_ready = 1'b1;
        idle(3);

        // Saturation of the illegal counter.
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            instr      = $urandom;
            instr[6:0] = 7'($urandom_range(16, 127));
            applyStimulus(instr);
        end
        drain();
        checkOutput("cnt_saturated", 64'(ifc.illegal_cnt), 64'(CNT_MAX));

        // Randomized traffic with random downstream stalls and occasional flushes.
        randReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       applyFlush(1'($urandom_range(0, 1)), $urandom);
                1:       idle(1);
                default: applyStimulus(randomInstr());
            endcase
        end
        randReady = 1'b0;
        drain();

        // Asynchronous reset in the middle of a stalled stream.
        ifc.out_ready = 1'b0;
        applyStimulus(32'h0FF0_0A05);
        applyStimulus(32'hF000_0185);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        modelCnt = 0;
        #1;
        checkOutput("arst_out_valid", 64'(ifc.out_valid), 64'd0);
        checkOutput("arst_in_ready", 64'(ifc.in_ready), 64'd1);
        checkOutput("arst_opcode", 64'(ifc.opcode), 64'd0);
        checkOutput("arst_ops", 64'({ifc.op1, ifc.op2}), 64'd0);
        checkOutput("arst_illegal", 64'(ifc.illegal), 64'd0);
        checkOutput("arst_cnt", 64'(ifc.illegal_cnt), 64'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(randomInstr());
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
